// File: rtl/hero_write_arb_pkg.sv
// hero_write_arb_pkg
// Shared hero bus definitions. This file holds the beat cycle-type encoding,
// the arbiter state encoding, and the default bus width and burst limit
// constants. It also provides a small wrap-around increment helper.
// Ports: none (package).
package hero_write_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        DONE  = 2'd2
    } cycle_type_e;

    typedef enum logic {
        ARB = 1'b0,
        OWN = 1'b1
    } arb_state_e;

    localparam int HERO_WIDTH_DEF = 32;
    localparam int MAX_BURST_DEF  = 16;

    // Next requester index after idx, wrapping at n (n need not be a power of two).
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/hero_write_arb_rr_pick.sv
// rr_pick
// Round-robin winner search. The search starts at ptr and wraps around.
// It returns the first requester whose req bit is set.
// Ports:
//   req   - one bit per requester, set when that requester is eligible
//   ptr   - index where the search starts (highest priority this cycle)
//   valid - high when any requester is eligible
//   index - winning requester index (0 when valid is low)
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] index
);

    // Walk the offsets from farthest to nearest. This way the requester
    // closest to ptr overwrites any earlier hit and ends up winning.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                valid = 1'b1;
                index = IW'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/hero_write_arb.sv
// hero_write_arb
// This module arbitrates burst writes from NUM_REQ requesters onto one hero bus.
// A requester wins in round-robin order and keeps the bus until its DONE beat.
// It also loses the bus when it reaches MAX_BURST beats; that last beat is sent
// out as DONE and trunc_pulse is raised. The output is a single registered stage.
// Ports:
//   clk, rst_n            - clock and asynchronous active-low reset
//   req_valid/cycle/data  - per-requester beat offer (cycle VALID or DONE)
//   req_ready             - per-requester accept (combinational grant)
//   hero_cycle/data/src   - registered hero bus beat, owner index
//   hero_ready            - downstream accepts the current non-IDLE beat
//   trunc_pulse           - one-cycle flag on a beat forced to DONE
module hero_write_arb
    import hero_write_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int HERO_WIDTH = HERO_WIDTH_DEF,
    parameter int MAX_BURST  = MAX_BURST_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0][1:0]              req_cycle,
    input  logic [NUM_REQ-1:0][HERO_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic [1:0]                           hero_cycle,
    output logic [HERO_WIDTH-1:0]                hero_data,
    output logic [$clog2(NUM_REQ)-1:0]           hero_src,
    input  logic                                 hero_ready,
    output logic                                 trunc_pulse
);

    localparam int SRC_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e        state;
    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W-1:0]  owner;
    logic [CNT_W-1:0]  beat_cnt;

    logic [NUM_REQ-1:0] req_live;
    logic               stage_free;
    logic               pick_valid;
    logic [SRC_W-1:0]   pick_idx;
    logic [SRC_W-1:0]   sel;
    logic [SRC_W-1:0]   next_ptr;
    cycle_type_e        sel_cycle;
    logic               accept;
    logic               truncate;

    // A requester counts as eligible only when it is valid and its cycle is
    // not IDLE. An IDLE offer is invisible to the arbiter.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_live[i] = req_valid[i] && (cycle_type_e'(req_cycle[i]) != IDLE);
        end
    end

    assign stage_free = (cycle_type_e'(hero_cycle) == IDLE) || hero_ready;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (SRC_W)
    ) u_rr_pick (
        .req   (req_live),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .index (pick_idx)
    );

    // Combinational grant. In ARB the round-robin winner gets ready. In OWN
    // only the owner gets ready, and only when it offers a non-IDLE beat.
    // Both cases need the output stage to be free. Reset masks all grants.
    always_comb begin
        req_ready = '0;
        sel       = owner;
        if (state == ARB) begin
            sel = pick_idx;
            if (pick_valid && stage_free) begin
                req_ready[pick_idx] = 1'b1;
            end
        end else if (stage_free && (cycle_type_e'(req_cycle[owner]) != IDLE)) begin
            req_ready[owner] = 1'b1;
        end
        if (!rst_n) begin
            req_ready = '0;
        end
        accept    = |(req_valid & req_ready);
        sel_cycle = cycle_type_e'(req_cycle[sel]);
        // beat_cnt holds the number of beats already taken. The beat being
        // accepted now is therefore beat number beat_cnt+1.
        truncate  = (state == OWN) && accept && (sel_cycle == VALID) &&
                    (beat_cnt == CNT_W'(MAX_BURST - 1));
        next_ptr  = SRC_W'(wrap_inc(int'(sel), NUM_REQ));
    end

    // This block holds the output stage and the ARB/OWN state machine.
    // Every accepted beat loads the stage. A free stage with no accept
    // drains to IDLE. The pointer moves past a requester when its burst ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARB;
            rr_ptr      <= '0;
            owner       <= '0;
            beat_cnt    <= '0;
            hero_cycle  <= IDLE;
            hero_data   <= '0;
            hero_src    <= '0;
            trunc_pulse <= 1'b0;
        end else begin
            trunc_pulse <= 1'b0;
            if (stage_free) begin
                if (accept) begin
                    hero_cycle  <= truncate ? DONE : sel_cycle;
                    hero_data   <= req_data[sel];
                    hero_src    <= sel;
                    trunc_pulse <= truncate;
                end else begin
                    hero_cycle  <= IDLE;
                end
            end
            if (accept) begin
                if (state == ARB) begin
                    if (sel_cycle == VALID) begin
                        owner    <= sel;
                        beat_cnt <= CNT_W'(1);
                        state    <= OWN;
                    end else begin
                        rr_ptr   <= next_ptr;
                    end
                end else begin
                    if ((sel_cycle == DONE) || truncate) begin
                        state    <= ARB;
                        beat_cnt <= '0;
                        rr_ptr   <= next_ptr;
                    end else begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_hero_write_arb.sv
// tb_hero_write_arb
// Directed bench for hero_write_arb with NUM_REQ=4, HERO_WIDTH=32, MAX_BURST=4.
// Each requester is fed from a queue of beats. The head beat is popped when a
// handshake is seen. Every beat the hero bus delivers is logged, and the log
// is compared with hand-written expected sequences.
module tb_hero_write_arb;

    localparam int NR = 4;
    localparam int W  = 32;
    localparam int MB = 4;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b1;
    logic [NR-1:0]       req_valid;
    logic [NR-1:0][1:0]  req_cycle;
    logic [NR-1:0][W-1:0] req_data;
    logic [NR-1:0]       req_ready;
    logic [1:0]          hero_cycle;
    logic [W-1:0]        hero_data;
    logic [1:0]          hero_src;
    logic                hero_ready;
    logic                trunc_pulse;

    always #5 clk = ~clk;

    hero_write_arb #(
        .NUM_REQ    (NR),
        .HERO_WIDTH (W),
        .MAX_BURST  (MB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_cycle   (req_cycle),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .hero_cycle  (hero_cycle),
        .hero_data   (hero_data),
        .hero_src    (hero_src),
        .hero_ready  (hero_ready),
        .trunc_pulse (trunc_pulse)
    );

    typedef struct packed {
        logic [31:0]  t;
        logic [W-1:0] data;
        logic [1:0]   cyc;
        logic [1:0]   src;
        logic         trunc;
    } beat_t;

    logic [1:0]   q_cyc[NR][$];
    logic [W-1:0] q_dat[NR][$];
    beat_t        log_q[$];

    int tests = 0;
    int fails = 0;
    int cyc_n = 0;
    int trunc_cnt = 0;
    int busy_cnt = 0;
    logic [NR-1:0] ready_seen;
    logic [NR-1:0] s_ready;
    logic [1:0]    s_cycle;
    logic [W-1:0]  s_data;

    // Counts one comparison and reports it when the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives each requester's head-of-queue beat onto its ports, or drives idle when the queue is empty.
    task automatic present();
        for (int i = 0; i < NR; i++) begin
            if (q_cyc[i].size() > 0) begin
                req_valid[i] = 1'b1;
                req_cycle[i] = q_cyc[i][0];
                req_data[i]  = q_dat[i][0];
            end else begin
                req_valid[i] = 1'b0;
                req_cycle[i] = 2'd0;
                req_data[i]  = '0;
            end
        end
    endtask

    task automatic pushBeat(input int r, input logic [1:0] c, input logic [W-1:0] d);
        q_cyc[r].push_back(c);
        q_dat[r].push_back(d);
    endtask

    // One clock: sample at the falling edge, then pop the accepted beats after the rising edge and present the next ones.
    task automatic applyStimulus();
        logic [NR-1:0] acc;
        @(negedge clk);
        cyc_n++;
        s_ready = req_ready;
        s_cycle = hero_cycle;
        s_data  = hero_data;
        acc = req_valid & req_ready;
        ready_seen = ready_seen | req_ready;
        if (trunc_pulse) trunc_cnt++;
        if (hero_cycle != 2'd0) busy_cnt++;
        if (hero_cycle != 2'd0 && hero_ready)
            log_q.push_back('{t: 32'(cyc_n), data: hero_data, cyc: hero_cycle,
                              src: hero_src, trunc: trunc_pulse});
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc[i] && q_cyc[i].size() > 0) begin
                void'(q_cyc[i].pop_front());
                void'(q_dat[i].pop_front());
            end
        end
        present();
    endtask

    task automatic runCycles(input int n);
        repeat (n) applyStimulus();
    endtask

    task automatic clearQueues();
        for (int i = 0; i < NR; i++) begin
            q_cyc[i].delete();
            q_dat[i].delete();
        end
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        hero_ready = 1'b1;
        clearQueues();
        present();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        log_q.delete();
        cyc_n = 0;
        trunc_cnt = 0;
        busy_cnt = 0;
        ready_seen = '0;
    endtask

    // Checks logged beat k. A missing beat is itself reported as a failure.
    task automatic checkBeat(input string tag, input int k, input logic [1:0] src,
                             input logic [1:0] c, input logic [W-1:0] d, input logic tr);
        if (k < log_q.size()) begin
            checkOutput({tag, "_src"},   32'(log_q[k].src),   32'(src));
            checkOutput({tag, "_cyc"},   32'(log_q[k].cyc),   32'(c));
            checkOutput({tag, "_data"},  log_q[k].data,       d);
            checkOutput({tag, "_trunc"}, 32'(log_q[k].trunc), 32'(tr));
        end else begin
            checkOutput({tag, "_missing"}, 32'(log_q.size()), 32'(k + 1));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0] exp_src4 [5];
        logic [W-1:0] exp_dat4 [5];

        // Reset values, with requester 0 offering a beat while reset is held.
        hero_ready = 1'b1;
        ready_seen = '0;
        clearQueues();
        pushBeat(0, 2'd2, 32'h1);
        present();
        #1 rst_n = 1'b0;
        #12;
        checkOutput("rst_hero_cycle", 32'(hero_cycle), 32'd0);
        checkOutput("rst_hero_data",  hero_data,       32'd0);
        checkOutput("rst_hero_src",   32'(hero_src),   32'd0);
        checkOutput("rst_trunc",      32'(trunc_pulse), 32'd0);
        checkOutput("rst_req_ready",  32'(req_ready),  32'd0);

        // Two 3-beat bursts: requester 0 completes before requester 2 starts.
        applyReset();
        pushBeat(0, 2'd1, 32'h100); pushBeat(0, 2'd1, 32'h101); pushBeat(0, 2'd2, 32'h102);
        pushBeat(2, 2'd1, 32'h200); pushBeat(2, 2'd1, 32'h201); pushBeat(2, 2'd2, 32'h202);
        present();
        applyStimulus();
        checkOutput("s1_first_grant", 32'(s_ready), 32'h1);
        runCycles(9);
        checkOutput("s1_count", 32'(log_q.size()), 32'd6);
        checkBeat("s1_b0", 0, 2'd0, 2'd1, 32'h100, 1'b0);
        checkBeat("s1_b1", 1, 2'd0, 2'd1, 32'h101, 1'b0);
        checkBeat("s1_b2", 2, 2'd0, 2'd2, 32'h102, 1'b0);
        checkBeat("s1_b3", 3, 2'd2, 2'd1, 32'h200, 1'b0);
        checkBeat("s1_b4", 4, 2'd2, 2'd1, 32'h201, 1'b0);
        checkBeat("s1_b5", 5, 2'd2, 2'd2, 32'h202, 1'b0);
        if (log_q.size() == 6) begin
            checkOutput("s1_latency", log_q[0].t, 32'd2);
            checkOutput("s1_span",    log_q[5].t - log_q[0].t, 32'd5);
        end

        // Six VALID beats and then DONE, with MAX_BURST=4: beat 4 is forced to DONE.
        applyReset();
        for (int k = 0; k < 6; k++) pushBeat(1, 2'd1, 32'h10 + 32'(k));
        pushBeat(1, 2'd2, 32'h16);
        present();
        runCycles(12);
        checkOutput("s2_count", 32'(log_q.size()), 32'd7);
        checkBeat("s2_b0", 0, 2'd1, 2'd1, 32'h10, 1'b0);
        checkBeat("s2_b2", 2, 2'd1, 2'd1, 32'h12, 1'b0);
        checkBeat("s2_b3", 3, 2'd1, 2'd2, 32'h13, 1'b1);
        checkBeat("s2_b4", 4, 2'd1, 2'd1, 32'h14, 1'b0);
        checkBeat("s2_b5", 5, 2'd1, 2'd1, 32'h15, 1'b0);
        checkBeat("s2_b6", 6, 2'd1, 2'd2, 32'h16, 1'b0);
        checkOutput("s2_trunc_cnt", 32'(trunc_cnt), 32'd1);

        // Hold hero_ready low for 5 cycles while a mid-burst beat is in the stage.
        applyReset();
        pushBeat(0, 2'd1, 32'h30); pushBeat(0, 2'd1, 32'h31);
        pushBeat(0, 2'd1, 32'h32); pushBeat(0, 2'd2, 32'h33);
        present();
        runCycles(2);
        hero_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus();
            checkOutput("s3_hold_cyc",   32'(s_cycle), 32'd1);
            checkOutput("s3_hold_data",  s_data,       32'h31);
            checkOutput("s3_hold_ready", 32'(s_ready), 32'd0);
        end
        hero_ready = 1'b1;
        runCycles(6);
        checkOutput("s3_count", 32'(log_q.size()), 32'd4);
        checkBeat("s3_b0", 0, 2'd0, 2'd1, 32'h30, 1'b0);
        checkBeat("s3_b1", 1, 2'd0, 2'd1, 32'h31, 1'b0);
        checkBeat("s3_b2", 2, 2'd0, 2'd1, 32'h32, 1'b0);
        checkBeat("s3_b3", 3, 2'd0, 2'd2, 32'h33, 1'b0);

        // All four requesters send single-beat DONE: grant order is 0,1,2,3,0.
        applyReset();
        pushBeat(0, 2'd2, 32'hA0); pushBeat(0, 2'd2, 32'hA1);
        pushBeat(1, 2'd2, 32'hB0); pushBeat(2, 2'd2, 32'hC0); pushBeat(3, 2'd2, 32'hD0);
        present();
        runCycles(8);
        exp_src4 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_dat4 = '{32'hA0, 32'hB0, 32'hC0, 32'hD0, 32'hA1};
        checkOutput("s4_count", 32'(log_q.size()), 32'd5);
        for (int k = 0; k < 5; k++) checkBeat("s4_b", k, exp_src4[k], 2'd2, exp_dat4[k], 1'b0);
        if (log_q.size() == 5) checkOutput("s4_span", log_q[4].t - log_q[0].t, 32'd4);

        // Reset during beat 2 of a burst from requester 2, then check that arbitration restarts at 0.
        applyReset();
        pushBeat(2, 2'd1, 32'h20); pushBeat(2, 2'd1, 32'h21); pushBeat(2, 2'd2, 32'h22);
        present();
        runCycles(2);
        checkOutput("s5_pre_cyc", 32'(hero_cycle), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("s5_async_cyc",   32'(hero_cycle), 32'd0);
        checkOutput("s5_async_ready", 32'(req_ready),  32'd0);
        applyReset();
        pushBeat(0, 2'd2, 32'h50); pushBeat(3, 2'd2, 32'h60);
        present();
        runCycles(6);
        checkOutput("s5_count", 32'(log_q.size()), 32'd2);
        checkBeat("s5_b0", 0, 2'd0, 2'd2, 32'h50, 1'b0);
        checkBeat("s5_b1", 1, 2'd3, 2'd2, 32'h60, 1'b0);

        // Requester 3 asserts valid with an IDLE cycle: it is never granted.
        applyReset();
        pushBeat(3, 2'd0, 32'h77);
        present();
        runCycles(6);
        checkOutput("s6_ready3", 32'(ready_seen[3]), 32'd0);
        checkOutput("s6_busy",   32'(busy_cnt),      32'd0);
        checkOutput("s6_count",  32'(log_q.size()),  32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hero_write_arb.md
HERO_WRITE_ARB -- requirements
Module: hero_write_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of hero-write requesters, legal range 2..8.
REQ-002 Parameter HERO_WIDTH, default 32: hero bus data width.
REQ-003 Parameter MAX_BURST, default 16: maximum beats per granted burst before forced release, legal range 2..256.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port req_valid, input, NUM_REQ bits: per-requester beat offered.
REQ-007 Port req_cycle, input, NUM_REQ x 2 bits: per-requester CYCLE_TYPE_E, VALID for a mid-burst beat, DONE for the last beat.
REQ-008 Port req_data, input, NUM_REQ x HERO_WIDTH bits: per-requester write data.
REQ-009 Port req_ready, output, NUM_REQ bits: beat accepted this cycle when both req_valid and req_ready are high.
REQ-010 Port hero_cycle, output, 2 bits: CYCLE_TYPE_E of the hero bus beat; IDLE means no beat.
REQ-011 Port hero_data, output, HERO_WIDTH bits: hero bus data.
REQ-012 Port hero_src, output, clog2(NUM_REQ) bits: index of the requester that owns the current beat.
REQ-013 Port hero_ready, input, 1 bit: downstream accepts a non-IDLE beat this cycle.
REQ-014 Port trunc_pulse, output, 1 bit: one-cycle pulse when a burst is force-terminated at MAX_BURST.

Function
REQ-015 Outputs are registered through one stage. The stage is empty when hero_cycle is IDLE. The stage loads when it is empty or when hero_ready is high.
REQ-016 A non-IDLE beat holds hero_cycle, hero_data and hero_src stable while hero_ready is low.
REQ-017 State machine ARB: no owner. A round-robin search starts at rr_ptr over requesters whose req_valid is high and whose req_cycle is not IDLE.
REQ-018 ARB with a winner and the stage free: assert req_ready for the winner only, in the same cycle (combinational grant).
  - Winner beat VALID: capture owner, set beat_cnt=1, go to OWN.
  - Winner beat DONE: single-beat burst; stay in ARB and set rr_ptr=winner+1 mod NUM_REQ.
REQ-019 OWN: req_ready is high only for the owner, and only when the stage is free. All other requesters see req_ready low.
REQ-020 OWN, owner beat accepted:
  - beat_cnt increments.
  - A DONE beat returns to ARB and sets rr_ptr=owner+1.
REQ-021 OWN, truncation: when an accepted VALID beat is beat number MAX_BURST, drive that beat out as DONE.
  - Pulse trunc_pulse in the cycle the beat loads the stage.
  - Return to ARB and set rr_ptr=owner+1.
  - Later beats from that requester arbitrate as a new burst.
REQ-022 A req_valid high with req_cycle IDLE is treated as not valid and never gets req_ready.
REQ-023 In OWN, the owner dropping req_valid keeps ownership; there is no timeout other than MAX_BURST beats.
REQ-024 Transfer throughput is one beat per cycle while hero_ready stays high; with the stage empty, latency from req accept to hero_cycle is one cycle.
REQ-025 beat_cnt is clog2(MAX_BURST+1) bits wide and never wraps; it resets to 0 on entering ARB.

Reset
REQ-026 rst_n low asynchronously forces:
  - state ARB, rr_ptr=0, beat_cnt=0;
  - hero_cycle=IDLE, hero_data=0, hero_src=0;
  - trunc_pulse=0, req_ready all 0.
REQ-027 Reset mid-burst discards the in-flight beat and ownership; after release, arbitration restarts from requester 0.

Structure
REQ-028 CYCLE_TYPE_E (IDLE=0, VALID=1, DONE=2) comes from the shared hero package. The default HERO_WIDTH and MAX_BURST constants live there as well.
REQ-029 The round-robin winner search is a separate sub-module, rr_pick, with inputs req vector and ptr and outputs valid and index.

Verification
REQ-030 Scenario: requesters 0 and 2 each present a 3-beat burst (VALID, VALID, DONE) at t0, hero_ready=1. Required response: beats from requester 0, then requester 2, with no interleave; hero_src sequence 0,0,0,2,2,2; first beat at t0+1.
REQ-031 Scenario: MAX_BURST=4, requester 1 sends 6 VALID beats then DONE. Required response:
  - beat 4 appears as DONE with trunc_pulse=1;
  - remaining 3 beats form a second burst, ending DONE.
REQ-032 Scenario: mid-burst beat, hold hero_ready=0 for 5 cycles. Required response: the output stays stable, req_ready=0, and no beat is lost or duplicated after release.
REQ-033 Scenario: all 4 requesters send single-beat DONE continuously. Required response: grant order 0,1,2,3,0 with one beat per cycle.
REQ-034 Scenario: assert rst_n=0 at beat 2 of a 3-beat burst. Required response: hero_cycle=IDLE immediately; after release, requester 0 wins over requester 3 when both request.
REQ-035 Scenario: req_valid=1 with req_cycle=IDLE on requester 3. Required response: req_ready[3] never asserts, and hero_cycle stays IDLE.
